// File: rtl/pgr_fft_pair_aligner.sv
// Aligns sample-RAM read data with its delayed request sideband and regroups
// pair-mode beats into butterfly operand entries held in a FWFT output FIFO.
module pgr_fft_pair_aligner #(
  parameter int DATA_WIDTH    = 18,
  parameter int TWIDDLE_WIDTH = 18,
  parameter int ADDR_WIDTH    = 10,
  parameter int RD_LAT        = 1,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     first_level,
  input  logic                     i_rd_req,
  input  logic [ADDR_WIDTH-1:0]    i_rd_addr,
  input  logic [TWIDDLE_WIDTH-1:0] twiddle_data,
  input  logic [DATA_WIDTH-1:0]    ia_rd_data,
  input  logic [DATA_WIDTH-1:0]    ib_rd_data,
  output logic                     o_vld,
  input  logic                     o_rdy,
  output logic [DATA_WIDTH-1:0]    o_ain,
  output logic [DATA_WIDTH-1:0]    o_bin,
  output logic [TWIDDLE_WIDTH-1:0] o_twiddle,
  output logic [ADDR_WIDTH-1:0]    o_addr,
  output logic                     o_first_lev,
  output logic                     o_afull,
  output logic                     o_pair_err,
  output logic                     o_ovf
);
  localparam int PW = $clog2(FIFO_DEPTH);

  // request delay line, matched to the RAM read latency
  logic [RD_LAT-1:0]                    r_req_d;
  logic [RD_LAT-1:0]                    r_fl_d;
  logic [RD_LAT-1:0][ADDR_WIDTH-1:0]    r_addr_d;
  logic [RD_LAT-1:0][TWIDDLE_WIDTH-1:0] r_tw_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_d  <= '0;
      r_fl_d   <= '0;
      r_addr_d <= '0;
      r_tw_d   <= '0;
    end else begin
      r_req_d[0]  <= i_rd_req;
      r_fl_d[0]   <= first_level;
      r_addr_d[0] <= i_rd_addr;
      r_tw_d[0]   <= twiddle_data;
      for (int i = 1; i < RD_LAT; i++) begin
        r_req_d[i]  <= r_req_d[i-1];
        r_fl_d[i]   <= r_fl_d[i-1];
        r_addr_d[i] <= r_addr_d[i-1];
        r_tw_d[i]   <= r_tw_d[i-1];
      end
    end
  end

  logic                     w_dv, w_fl_d;
  logic [ADDR_WIDTH-1:0]    w_addr_d;
  logic [TWIDDLE_WIDTH-1:0] w_tw_d;
  assign w_dv     = r_req_d[RD_LAT-1];
  assign w_fl_d   = r_fl_d[RD_LAT-1];
  assign w_addr_d = r_addr_d[RD_LAT-1];
  assign w_tw_d   = r_tw_d[RD_LAT-1];

  // burst tracking and pair regrouping
  logic                     r_dv_q, r_fl_mode, r_phase, r_pair_err;
  logic [DATA_WIDTH-1:0]    r_a0, r_b0;
  logic [TWIDDLE_WIDTH-1:0] r_tw0;
  logic [ADDR_WIDTH-1:0]    r_addr0;
  logic                     r_pend_vld;
  logic [DATA_WIDTH-1:0]    r_pend_a, r_pend_b;
  logic [TWIDDLE_WIDTH-1:0] r_pend_tw;
  logic [ADDR_WIDTH-1:0]    r_pend_addr;

  logic w_start, w_fl_mode, w_phase, w_end_err;
  assign w_start   = w_dv & ~r_dv_q;
  assign w_fl_mode = w_start ? w_fl_d : r_fl_mode;
  assign w_phase   = w_start ? 1'b0 : r_phase;
  assign w_end_err = ~w_dv & r_dv_q & ~r_fl_mode & r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dv_q      <= 1'b0;
      r_fl_mode   <= 1'b0;
      r_phase     <= 1'b0;
      r_pair_err  <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_a0        <= '0;
      r_b0        <= '0;
      r_tw0       <= '0;
      r_addr0     <= '0;
      r_pend_a    <= '0;
      r_pend_b    <= '0;
      r_pend_tw   <= '0;
      r_pend_addr <= '0;
    end else begin
      r_dv_q     <= w_dv;
      r_fl_mode  <= w_fl_mode;
      r_pair_err <= w_end_err;
      r_pend_vld <= 1'b0;
      if (w_end_err) r_phase <= 1'b0;
      if (w_dv && !w_fl_mode) begin
        if (!w_phase) begin
          r_a0    <= ia_rd_data;
          r_b0    <= ib_rd_data;
          r_tw0   <= w_tw_d;
          r_addr0 <= w_addr_d;
          r_phase <= 1'b1;
        end else begin
          r_pend_vld  <= 1'b1;
          r_pend_a    <= r_b0;
          r_pend_b    <= ib_rd_data;
          r_pend_tw   <= w_tw_d;
          r_pend_addr <= w_addr_d;
          r_phase     <= 1'b0;
        end
      end else if (w_dv) begin
        r_phase <= 1'b0;
      end
    end
  end

  // a pending half can only follow a phase-1 beat, so it never meets another push
  logic                     w_push, w_p_fl;
  logic [DATA_WIDTH-1:0]    w_p_a, w_p_b;
  logic [TWIDDLE_WIDTH-1:0] w_p_tw;
  logic [ADDR_WIDTH-1:0]    w_p_addr;

  always_comb begin
    w_push   = 1'b0;
    w_p_a    = '0;
    w_p_b    = '0;
    w_p_tw   = '0;
    w_p_addr = '0;
    w_p_fl   = 1'b0;
    if (r_pend_vld) begin
      w_push   = 1'b1;
      w_p_a    = r_pend_a;
      w_p_b    = r_pend_b;
      w_p_tw   = r_pend_tw;
      w_p_addr = r_pend_addr;
    end else if (w_dv && w_fl_mode) begin
      w_push   = 1'b1;
      w_p_a    = ia_rd_data;
      w_p_b    = ib_rd_data;
      w_p_tw   = w_tw_d;
      w_p_addr = w_addr_d;
      w_p_fl   = 1'b1;
    end else if (w_dv && w_phase) begin
      w_push   = 1'b1;
      w_p_a    = r_a0;
      w_p_b    = ia_rd_data;
      w_p_tw   = r_tw0;
      w_p_addr = r_addr0;
    end
  end

  // FWFT output FIFO; pointers carry one extra wrap bit
  logic [DATA_WIDTH-1:0]    r_mem_a    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    r_mem_b    [FIFO_DEPTH];
  logic [TWIDDLE_WIDTH-1:0] r_mem_tw   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]    r_mem_addr [FIFO_DEPTH];
  logic                     r_mem_fl   [FIFO_DEPTH];
  logic [PW:0]              r_wptr, r_rptr;
  logic                     r_ovf;

  logic [PW:0] w_count;
  logic        w_empty, w_full, w_pop, w_wr;
  assign w_count = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (w_count == (PW+1)'(FIFO_DEPTH));
  assign w_pop   = ~w_empty & o_rdy;
  assign w_wr    = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_a[r_wptr[PW-1:0]]    <= w_p_a;
      r_mem_b[r_wptr[PW-1:0]]    <= w_p_b;
      r_mem_tw[r_wptr[PW-1:0]]   <= w_p_tw;
      r_mem_addr[r_wptr[PW-1:0]] <= w_p_addr;
      r_mem_fl[r_wptr[PW-1:0]]   <= w_p_fl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  // head fields read as zero while empty so nothing stale leaks after reset
  assign o_vld       = ~w_empty;
  assign o_ain       = w_empty ? '0 : r_mem_a[r_rptr[PW-1:0]];
  assign o_bin       = w_empty ? '0 : r_mem_b[r_rptr[PW-1:0]];
  assign o_twiddle   = w_empty ? '0 : r_mem_tw[r_rptr[PW-1:0]];
  assign o_addr      = w_empty ? '0 : r_mem_addr[r_rptr[PW-1:0]];
  assign o_first_lev = w_empty ? 1'b0 : r_mem_fl[r_rptr[PW-1:0]];
  assign o_afull     = (FIFO_DEPTH - int'(w_count)) <= (RD_LAT + 2);
  assign o_pair_err  = r_pair_err;
  assign o_ovf       = r_ovf;

endmodule
